axis_stream_fifo: RTL and testbench
===================================

# axis_stream_fifo

- Synchronous AXI-Stream elastic FIFO inserted between `DMA_Controller` and the `accelerator` on the DMA->ASIC stream.
- Decouples DMA burst reads from BRAM from accelerator back-pressure and carries `tlast` with every beat.
- Reports occupancy, stored-frame count and frame-completion pulses for DMA status registers.
- A second instance may be placed on the ASIC->DMA return path unchanged.

## Interface
Parameters:
- DATA_W, 32, payload width in bits.
- DEPTH, 8, number of entries; power of two, at least 2.
- CW, $clog2(DEPTH)+1, width of the count outputs (derived).

Ports:
- wb_clk_i  in  1  sole clock; all logic is rising-edge.
- wb_rst_i  in  1  reset, asynchronous and active-high.
- flush  in  1  synchronous clear of all contents.
- s_tvalid  in  1  upstream beat valid.
- s_tdata  in  DATA_W  upstream payload.
- s_tlast  in  1  upstream end-of-frame marker.
- s_tready  out  1  FIFO can accept a beat.
- m_tvalid  out  1  output beat valid.
- m_tdata  out  DATA_W  output payload.
- m_tlast  out  1  output end-of-frame marker.
- m_tready  in  1  downstream accepts the beat.
- level  out  CW  entries currently stored, 0..DEPTH.
- frame_cnt  out  CW  stored entries with tlast=1.
- pkt_done  out  1  one-cycle pulse after a tlast beat leaves.

## Operation
- Storage: DEPTH x (DATA_W+1) register array holding data and tlast, written at wr_ptr and read at rd_ptr.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH with no special case.
- Push happens when s_tvalid & s_tready & ~flush; write at wr_ptr, then wr_ptr+1.
- Pop happens when m_tvalid & m_tready & ~flush; rd_ptr+1.
- First-word-fall-through: m_tdata and m_tlast always show the entry at rd_ptr. m_tvalid = (level != 0).
- s_tready = (level != DEPTH) & ~flush.
  - It depends only on registered state and flush, never on m_tready.
  - When full, a same-cycle pop does not enable a push.
- level updates as level + push - pop. Simultaneous push and pop at any non-full, non-empty level leaves level unchanged.
- frame_cnt updates as frame_cnt + (push & s_tlast) - (pop & m_tlast).
- pkt_done is registered: high for exactly the cycle after a pop with m_tlast=1, otherwise low.
- flush sampled high at an edge:
  - wr_ptr, rd_ptr, level and frame_cnt all go to 0.
  - Any beat offered that cycle is discarded. s_tready is already low, so no handshake completes.
  - pkt_done is forced to 0.
- Empty: m_tvalid=0 and m_tdata holds stale array contents. Consumers must not rely on it.
- Protocol rule: after reset or flush the DMA starts a new frame. The FIFO does not check frame structure.
- No overflow or underflow is possible by construction.
  - Simulation-only assertions must flag a push while full or a pop while empty.

## Timing
- Reset values: level=0, frame_cnt=0, m_tvalid=0, pkt_done=0, s_tready=1 (with flush low).
  - m_tdata and m_tlast are 0 because the array resets to 0.
- Reset is asynchronous: outputs change on the assertion of wb_rst_i without waiting for a clock.
- Reset mid-frame drops all contents. No pkt_done is produced for the dropped data.
- Latency: a beat pushed at edge N is valid on m_* in the cycle following edge N (one-cycle first-word latency). It can be popped at edge N+1.
- Throughput: one beat per cycle sustained in both directions whenever 0 < level < DEPTH.
- Full (level=DEPTH): s_tready=0.
  - A pop at edge N gives level=DEPTH-1 and s_tready=1 in the cycle after edge N.
  - This costs one bubble on the input side.
- Empty with a push at edge N: m_tvalid rises after edge N. No same-cycle bypass is allowed.
- When m_tready is low and m_tvalid is high, m_tdata and m_tlast must stay stable until the pop completes (AXI-Stream hold rule).

## Test plan
- Reset then push 8 beats 0x100..0x107 with m_tready=0, DEPTH=8:
  - level reads 8 and s_tready=0.
  - A 9th beat 0x108 is not accepted.
- With the FIFO full from the previous case, raise m_tready:
  - Output order is 0x100..0x107 with no gaps.
  - level decrements each cycle.
  - s_tready=1 one cycle after the first pop.
  - 0x108 is then accepted exactly once.
- Continuous streaming of 64 beats with both sides valid/ready every cycle:
  - level stays at 1.
  - Output data equals input data delayed one cycle.
  - Pointers wrap 8 times without corruption.
- Frames of lengths 3, 1 and 5 (tlast on the 3rd, 4th and 9th beats) with random m_tready:
  - frame_cnt tracks the stored tlast beats.
  - Three pkt_done pulses occur, each one cycle after its tlast pop.
- Load 5 beats, including a tlast, then assert flush for one cycle while s_tvalid=1:
  - Next cycle level=0, frame_cnt=0, m_tvalid=0.
  - The beat offered during flush is absent.
  - The next pushed value 0xABC is output first.
- Assert wb_rst_i asynchronously mid-cycle with level=3:
  - m_tvalid and level go to 0 immediately.
  - pkt_done stays 0.
  - Normal operation resumes on the first edge after release.

Source files
------------

// File: rtl/axis_stream_fifo.sv
// axis_stream_fifo
// Elastic AXI-Stream FIFO that sits between the DMA engine and the accelerator.
// Every beat carries its payload together with its tlast marker. The block also
// exports occupancy and frame counts and a frame-completion pulse for the DMA
// status registers. The read side is first-word-fall-through.
//
// Ports
//   wb_clk_i   : sole clock, all logic rising-edge
//   wb_rst_i   : asynchronous active-high reset
//   flush      : synchronous clear of all stored beats
//   s_tvalid / s_tdata / s_tlast / s_tready : upstream AXI-Stream slave side
//   m_tvalid / m_tdata / m_tlast / m_tready : downstream AXI-Stream master side
//   level      : number of entries currently stored (0..DEPTH)
//   frame_cnt  : number of stored entries whose tlast is set
//   pkt_done   : one-cycle pulse in the cycle after a tlast beat leaves
//
// DEPTH must be a power of two so the pointers can wrap by plain overflow.

module axis_stream_fifo #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CW     = $clog2(DEPTH) + 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              flush,
   input  logic              s_tvalid,
   input  logic [DATA_W-1:0] s_tdata,
   input  logic              s_tlast,
   output logic              s_tready,
   output logic              m_tvalid,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tlast,
   input  logic              m_tready,
   output logic [CW-1:0]     level,
   output logic [CW-1:0]     frame_cnt,
   output logic              pkt_done
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

   // Each entry stores {tlast, data}.
   logic [DATA_W:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          push_last;
   logic          pop_last;
   logic [CW-1:0] level_next;
   logic [CW-1:0] frame_cnt_next;

   // Handshake qualification. s_tready is built only from registered state and
   // flush, so a pop in the same cycle never opens the input when full; this
   // keeps the ready path free of any combinational loop through m_tready.
   // flush closes both handshakes so nothing moves in a flush cycle.
   assign full      = (level == FULL_LEVEL);
   assign empty     = (level == '0);
   assign s_tready  = ~full & ~flush;
   assign m_tvalid  = ~empty;
   assign push      = s_tvalid & s_tready;
   assign pop       = m_tvalid & m_tready & ~flush;
   assign push_last = push & s_tlast;
   assign pop_last  = pop & m_tlast;

   // First-word-fall-through: the head entry is always presented. When empty
   // this is stale array contents and m_tvalid is low.
   assign {m_tlast, m_tdata} = mem[rd_ptr];

   // Storage array. It is cleared on reset so the outputs come up as zero,
   // but flush only moves the pointers and leaves old contents behind.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (push) begin
         mem[wr_ptr] <= {s_tlast, s_tdata};
      end
   end

   // Read and write pointers. Both wrap modulo DEPTH by natural overflow,
   // which is why DEPTH has to be a power of two.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Next occupancy and next frame count. A simultaneous push and pop leaves
   // the count where it is. The frame count follows the tlast bits of the
   // beats entering and leaving.
   always_comb begin
      level_next     = level;
      frame_cnt_next = frame_cnt;
      case ({push, pop})
         2'b10:   level_next = level + 1'b1;
         2'b01:   level_next = level - 1'b1;
         default: level_next = level;
      endcase
      case ({push_last, pop_last})
         2'b10:   frame_cnt_next = frame_cnt + 1'b1;
         2'b01:   frame_cnt_next = frame_cnt - 1'b1;
         default: frame_cnt_next = frame_cnt;
      endcase
   end

   // Occupancy and frame-count registers. flush clears both in one edge.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         level     <= '0;
         frame_cnt <= '0;
      end else if (flush) begin
         level     <= '0;
         frame_cnt <= '0;
      end else begin
         level     <= level_next;
         frame_cnt <= frame_cnt_next;
      end
   end

   // Frame-completion pulse. It is registered, so it appears in the cycle
   // after the tlast beat is taken. flush suppresses it.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         pkt_done <= 1'b0;
      end else if (flush) begin
         pkt_done <= 1'b0;
      end else begin
         pkt_done <= pop_last;
      end
   end

   // Simulation-time sanity checks. Overflow and underflow cannot happen by
   // construction, so any hit here points at a broken handshake. The head
   // entry must hold steady while it is valid and stalled.
   a_no_push_full: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      !(push && full));
   a_no_pop_empty: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      !(pop && empty));
   a_level_bound: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      (level <= FULL_LEVEL) && (frame_cnt <= level));
   a_hold_stable: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
      (m_tvalid && !m_tready && !flush) |=> $stable({m_tlast, m_tdata}));

endmodule

// File: tb/tb_axis_stream_fifo.sv
// tb_axis_stream_fifo
// Directed bench for axis_stream_fifo with DATA_W=32 and DEPTH=8. A table of
// {inputs, expected outputs} records covers fill, full back-pressure, drain,
// the tlast pulse and flush. Hand-written sequences cover continuous
// streaming, mixed frame lengths with an irregular m_tready pattern, and an
// asynchronous reset in mid-cycle.

module tb_axis_stream_fifo;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        s_tvalid;
   logic [31:0] s_tdata;
   logic        s_tlast;
   logic        s_tready;
   logic        m_tvalid;
   logic [31:0] m_tdata;
   logic        m_tlast;
   logic        m_tready;
   logic [3:0]  level;
   logic [3:0]  frame_cnt;
   logic        pkt_done;

   int check_count = 0;
   int pass_count  = 0;

   typedef struct {
      string       name;
      logic        s_tvalid;
      logic [31:0] s_tdata;
      logic        s_tlast;
      logic        m_tready;
      logic        flush;
      logic [3:0]  e_level;
      logic [3:0]  e_frame;
      logic        e_mvalid;
      logic        e_sready;
      logic        e_pkt;
      logic        chk_data;
      logic [31:0] e_tdata;
      logic        e_tlast;
   } vec_t;

   vec_t vecs[$];

   axis_stream_fifo #(.DATA_W(32), .DEPTH(8)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .flush    (flush),
      .s_tvalid (s_tvalid),
      .s_tdata  (s_tdata),
      .s_tlast  (s_tlast),
      .s_tready (s_tready),
      .m_tvalid (m_tvalid),
      .m_tdata  (m_tdata),
      .m_tlast  (m_tlast),
      .m_tready (m_tready),
      .level    (level),
      .frame_cnt(frame_cnt),
      .pkt_done (pkt_done)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts it, and reports a FAIL line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_count++;
      if (act !== exp) begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         pass_count++;
      end
   endtask

   task automatic add_vec(input string name, input logic sv, input logic [31:0] sd, input logic sl,
                          input logic mr, input logic fl, input int lv, input int fc, input logic mv,
                          input logic sr, input logic pk, input logic cd, input logic [31:0] td,
                          input logic tl);
      vec_t v;
      v.name = name;  v.s_tvalid = sv;  v.s_tdata = sd;  v.s_tlast = sl;
      v.m_tready = mr; v.flush = fl;   v.e_level = 4'(lv); v.e_frame = 4'(fc);
      v.e_mvalid = mv; v.e_sready = sr; v.e_pkt = pk;   v.chk_data = cd;
      v.e_tdata = td;  v.e_tlast = tl;
      vecs.push_back(v);
   endtask

   // Drives one record on the falling edge, then compares one step after the
   // next rising edge while the record's inputs are still applied.
   task automatic applyStimulus(input vec_t v, input int idx);
      string tag;
      @(negedge clk);
      s_tvalid = v.s_tvalid;
      s_tdata  = v.s_tdata;
      s_tlast  = v.s_tlast;
      m_tready = v.m_tready;
      flush    = v.flush;
      @(posedge clk);
      #1;
      tag = $sformatf("%s[%0d]", v.name, idx);
      checkOutput({tag, ".level"}, 32'(level), 32'(v.e_level));
      checkOutput({tag, ".frame_cnt"}, 32'(frame_cnt), 32'(v.e_frame));
      checkOutput({tag, ".m_tvalid"}, 32'(m_tvalid), 32'(v.e_mvalid));
      checkOutput({tag, ".s_tready"}, 32'(s_tready), 32'(v.e_sready));
      checkOutput({tag, ".pkt_done"}, 32'(pkt_done), 32'(v.e_pkt));
      if (v.chk_data) begin
         checkOutput({tag, ".m_tdata"}, m_tdata, v.e_tdata);
         checkOutput({tag, ".m_tlast"}, 32'(m_tlast), 32'(v.e_tlast));
      end
   endtask

   initial begin
      logic [32:0] mq[$];
      logic [32:0] head;
      logic [47:0] rdy_pat;
      int          idx;
      int          pulses;
      int          fc;
      logic        exp_sready;
      logic        do_push;
      logic        do_pop;
      logic        exp_pkt;
      logic        finished;

      // Table: fill to full, hold a ninth beat off, then drain.
      for (int i = 0; i < 8; i++) begin
         add_vec("fill", 1, 32'h100 + 32'(i), 0, 0, 0, i + 1, 0, 1, (i != 7), 0, 1, 32'h100, 0);
      end
      add_vec("full_hold",   1, 32'h108, 0, 0, 0, 8, 0, 1, 0, 0, 1, 32'h100, 0);
      add_vec("drain_first", 1, 32'h108, 0, 1, 0, 7, 0, 1, 1, 0, 1, 32'h101, 0);
      add_vec("drain_push",  1, 32'h108, 0, 1, 0, 7, 0, 1, 1, 0, 1, 32'h102, 0);
      for (int k = 0; k < 6; k++) begin
         add_vec("drain", 0, 0, 0, 1, 0, 6 - k, 0, 1, 1, 0, 1, 32'h103 + 32'(k), 0);
      end
      add_vec("drain_empty", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Single tlast beat in and out: pulse for exactly one cycle.
      add_vec("last_in",  1, 32'h77, 1, 0, 0, 1, 1, 1, 1, 0, 1, 32'h77, 1);
      add_vec("last_pop", 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      add_vec("last_idle", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
      // Load five beats with tlast on the third, flush while offering a beat.
      for (int i = 0; i < 5; i++) begin
         add_vec("preflush", 1, 32'h300 + 32'(i), (i == 2), 0, 0, i + 1, (i >= 2) ? 1 : 0,
                 1, 1, 0, 1, 32'h300, 0);
      end
      add_vec("flush",       1, 32'hDEAD, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      add_vec("after_flush", 1, 32'hABC, 0, 0, 0, 1, 0, 1, 1, 0, 1, 32'hABC, 0);
      add_vec("pop_abc",     0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // Reset values.
      rst = 1'b1; flush = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_tready = 1'b0;
      #12;
      checkOutput("reset.level", 32'(level), 0);
      checkOutput("reset.frame_cnt", 32'(frame_cnt), 0);
      checkOutput("reset.m_tvalid", 32'(m_tvalid), 0);
      checkOutput("reset.pkt_done", 32'(pkt_done), 0);
      checkOutput("reset.s_tready", 32'(s_tready), 1);
      checkOutput("reset.m_tdata", m_tdata, 0);
      checkOutput("reset.m_tlast", 32'(m_tlast), 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i], i);
      end

      // Continuous streaming: 64 beats, level pinned at 1, data one cycle late.
      @(negedge clk);
      s_tvalid = 1'b1; s_tdata = 32'h1000; s_tlast = 1'b0; m_tready = 1'b1; flush = 1'b0;
      @(posedge clk); #1;
      checkOutput("stream.first_level", 32'(level), 1);
      checkOutput("stream.first_data", m_tdata, 32'h1000);
      for (int k = 1; k < 64; k++) begin
         @(negedge clk);
         s_tdata = 32'h1000 + 32'(k);
         @(posedge clk); #1;
         checkOutput($sformatf("stream[%0d].level", k), 32'(level), 1);
         checkOutput($sformatf("stream[%0d].m_tdata", k), m_tdata, 32'h1000 + 32'(k));
      end
      @(negedge clk);
      s_tvalid = 1'b0;
      @(posedge clk); #1;
      checkOutput("stream.end_level", 32'(level), 0);

      // Frames of 3, 1 and 5 beats against an irregular m_tready pattern.
      rdy_pat  = 48'hFFFF_FFF5_A3C4;
      idx      = 0;
      pulses   = 0;
      finished = 1'b0;
      mq.delete();
      for (int cyc = 0; cyc < 48 && !finished; cyc++) begin
         @(negedge clk);
         s_tvalid = (idx < 9);
         s_tdata  = 32'h200 + 32'(idx);
         s_tlast  = (idx == 2) || (idx == 3) || (idx == 8);
         m_tready = rdy_pat[cyc];
         #1;
         exp_sready = (mq.size() != 8);
         checkOutput($sformatf("frames[%0d].s_tready", cyc), 32'(s_tready), 32'(exp_sready));
         do_push = s_tvalid && exp_sready;
         do_pop  = (mq.size() != 0) && m_tready;
         @(posedge clk); #1;
         exp_pkt = 1'b0;
         if (do_pop) begin
            head    = mq.pop_front();
            exp_pkt = head[32];
         end
         if (do_push) begin
            mq.push_back({s_tlast, s_tdata});
            idx++;
         end
         fc = 0;
         foreach (mq[j]) fc += int'(mq[j][32]);
         if (pkt_done === 1'b1) pulses++;
         checkOutput($sformatf("frames[%0d].level", cyc), 32'(level), 32'(mq.size()));
         checkOutput($sformatf("frames[%0d].frame_cnt", cyc), 32'(frame_cnt), 32'(fc));
         checkOutput($sformatf("frames[%0d].pkt_done", cyc), 32'(pkt_done), 32'(exp_pkt));
         if (mq.size() != 0) begin
            checkOutput($sformatf("frames[%0d].m_tdata", cyc), m_tdata, mq[0][31:0]);
            checkOutput($sformatf("frames[%0d].m_tlast", cyc), 32'(m_tlast), 32'(mq[0][32]));
         end
         finished = (idx == 9) && (mq.size() == 0);
      end
      checkOutput("frames.finished", 32'(finished), 1);
      checkOutput("frames.pkt_pulses", 32'(pulses), 3);

      // Asynchronous reset in mid-cycle with three beats stored.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         s_tvalid = 1'b1; s_tdata = 32'h400 + 32'(i); s_tlast = (i == 2); m_tready = 1'b0;
         @(posedge clk);
      end
      #1;
      checkOutput("async.pre_level", 32'(level), 3);
      #2;
      rst = 1'b1;
      s_tvalid = 1'b0; m_tready = 1'b1;
      #1;
      checkOutput("async.m_tvalid", 32'(m_tvalid), 0);
      checkOutput("async.level", 32'(level), 0);
      checkOutput("async.frame_cnt", 32'(frame_cnt), 0);
      checkOutput("async.pkt_done", 32'(pkt_done), 0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checkOutput($sformatf("async.hold_pkt[%0d]", i), 32'(pkt_done), 0);
      end
      @(negedge clk);
      rst = 1'b0;
      s_tvalid = 1'b1; s_tdata = 32'h55; s_tlast = 1'b1; m_tready = 1'b0;
      @(posedge clk); #1;
      checkOutput("async.resume_level", 32'(level), 1);
      checkOutput("async.resume_data", m_tdata, 32'h55);
      @(negedge clk);
      s_tvalid = 1'b0; m_tready = 1'b1;
      @(posedge clk); #1;
      checkOutput("async.resume_pkt", 32'(pkt_done), 1);
      checkOutput("async.resume_empty", 32'(level), 0);
      @(posedge clk); #1;
      checkOutput("async.pkt_clear", 32'(pkt_done), 0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
